mc_store_buffered: RTL and testbench

- Store port between a dataflow circuit and the memory-controller interface, with a parametrised FIFO between them.
- Joins the address and data input channels, then buffers up to DEPTH store requests.
- Issues each buffered request on the address and data memory channels. These two channels have independent handshakes (eager fork), so back-pressure on one does not stall the other.
- Reports pending stores so the controller can track completion and drain.

---
 rtl/mc_store_buffered.sv | 168 ++++++++++++++++
 tb/tb_mc_store_buffered.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_store_buffered.sv
// ---------------------------------------------------------------------------
// mc_store_buffered
//   Store port between a dataflow circuit and a memory-controller interface.
//   The address and data input channels are joined, then buffered in a
//   circular FIFO of DEPTH entries. The head entry is issued on two
//   independent memory channels (address and data). Each channel has its own
//   handshake and is tracked by a per-head sent flag, so back-pressure on one
//   channel never stalls the other. The head is popped once both channels
//   have accepted it.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   addrIn/_valid/_ready      store address from the circuit
//   dataIn/_valid/_ready      store data from the circuit
//   addrOut/_valid/_ready     address channel towards memory
//   dataToMem/_valid/_ready   data channel towards memory
//   pending_count             number of occupied FIFO entries (registered)
//   empty                     high when no store is pending (registered)
// ---------------------------------------------------------------------------
module mc_store_buffered #(
  parameter int DATA_TYPE = 32,
  parameter int ADDR_TYPE = 32,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] dataIn,
  input  logic                 dataIn_valid,
  output logic                 dataIn_ready,
  input  logic [ADDR_TYPE-1:0] addrIn,
  input  logic                 addrIn_valid,
  output logic                 addrIn_ready,
  output logic [DATA_TYPE-1:0] dataToMem,
  output logic                 dataToMem_valid,
  input  logic                 dataToMem_ready,
  output logic [ADDR_TYPE-1:0] addrOut,
  output logic                 addrOut_valid,
  input  logic                 addrOut_ready,
  output logic [CNT_W-1:0]     pending_count,
  output logic                 empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  // Pointer advance with explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == LAST_PTR) begin
      r = '0;
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

  // Storage
  logic [ADDR_TYPE-1:0] addr_mem_q [DEPTH];
  logic [DATA_TYPE-1:0] data_mem_q [DEPTH];

  // Control state
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, empty_d;
  logic             addr_sent_q, addr_sent_d;
  logic             data_sent_q, data_sent_d;

  // Internal handshake signals
  logic full_s;
  logic push_s;
  logic pop_s;
  logic addr_hs_s;
  logic data_hs_s;
  logic addr_done_s;
  logic data_done_s;

  // Input join: each ready only depends on the other input's valid and on
  // FIFO occupancy, never on the memory-side readies.
  always_comb begin
    full_s       = (count_q == DEPTH_CNT);
    addrIn_ready = dataIn_valid & ~full_s;
    dataIn_ready = addrIn_valid & ~full_s;
    push_s       = addrIn_valid & dataIn_valid & ~full_s;
  end

  // Eager fork on the head entry; a channel stays quiet once it has accepted.
  always_comb begin
    addrOut_valid   = ~empty_q & ~addr_sent_q;
    dataToMem_valid = ~empty_q & ~data_sent_q;
    addrOut         = addr_mem_q[rd_ptr_q];
    dataToMem       = data_mem_q[rd_ptr_q];
    addr_hs_s       = addrOut_valid & addrOut_ready;
    data_hs_s       = dataToMem_valid & dataToMem_ready;
    addr_done_s     = addr_sent_q | addr_hs_s;
    data_done_s     = data_sent_q | data_hs_s;
    pop_s           = ~empty_q & addr_done_s & data_done_s;
  end

  // Next-state computation for pointers, occupancy and sent flags.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    addr_sent_d = addr_sent_q;
    data_sent_d = data_sent_q;

    if (push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d    = ptr_inc(rd_ptr_q);
      addr_sent_d = 1'b0;
      data_sent_d = 1'b0;
    end else begin
      rd_ptr_d    = rd_ptr_q;
      addr_sent_d = addr_sent_q | addr_hs_s;
      data_sent_d = data_sent_q | data_hs_s;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    empty_d = (count_d == CNT_W'(0));
  end

  // Control registers; reset discards every entry including a half-sent head.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      addr_sent_q <= 1'b0;
      data_sent_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      addr_sent_q <= addr_sent_d;
      data_sent_q <= data_sent_d;
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      addr_mem_q[wr_ptr_q] <= addrIn;
      data_mem_q[wr_ptr_q] <= dataIn;
    end
  end

  // Occupancy reporting straight from registers.
  always_comb begin
    pending_count = count_q;
    empty         = empty_q;
  end

endmodule

// File: tb/tb_mc_store_buffered.sv
module tb_mc_store_buffered;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dataIn, addrIn;
  logic        dataIn_valid, addrIn_valid;
  logic        dataToMem_ready, addrOut_ready;

  // DEPTH=4 instance
  logic        dataIn_ready, addrIn_ready;
  logic [31:0] dataToMem, addrOut;
  logic        dataToMem_valid, addrOut_valid;
  logic [7:0]  pending_count;
  logic        empty;

  // DEPTH=3 instance (shares all inputs)
  logic        dataIn_ready3, addrIn_ready3;
  logic [31:0] dataToMem3, addrOut3;
  logic        dataToMem_valid3, addrOut_valid3;
  logic [7:0]  pending_count3;
  logic        empty3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_store_buffered #(.DATA_TYPE(32), .ADDR_TYPE(32), .DEPTH(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .dataIn(dataIn), .dataIn_valid(dataIn_valid), .dataIn_ready(dataIn_ready),
    .addrIn(addrIn), .addrIn_valid(addrIn_valid), .addrIn_ready(addrIn_ready),
    .dataToMem(dataToMem), .dataToMem_valid(dataToMem_valid), .dataToMem_ready(dataToMem_ready),
    .addrOut(addrOut), .addrOut_valid(addrOut_valid), .addrOut_ready(addrOut_ready),
    .pending_count(pending_count), .empty(empty)
  );

  mc_store_buffered #(.DATA_TYPE(32), .ADDR_TYPE(32), .DEPTH(3), .CNT_W(8)) u_dut3 (
    .clk(clk), .rst(rst),
    .dataIn(dataIn), .dataIn_valid(dataIn_valid), .dataIn_ready(dataIn_ready3),
    .addrIn(addrIn), .addrIn_valid(addrIn_valid), .addrIn_ready(addrIn_ready3),
    .dataToMem(dataToMem3), .dataToMem_valid(dataToMem_valid3), .dataToMem_ready(dataToMem_ready),
    .addrOut(addrOut3), .addrOut_valid(addrOut_valid3), .addrOut_ready(addrOut_ready),
    .pending_count(pending_count3), .empty(empty3)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic av, input logic dv);
    addrIn       = a;
    dataIn       = d;
    addrIn_valid = av;
    dataIn_valid = dv;
  endtask

  initial begin
    rst = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    addrOut_ready   = 1'b0;
    dataToMem_ready = 1'b0;
    tick();
    tick();

    // Reset state
    check_val("rst_pending", pending_count, 64'd0);
    check_val("rst_empty", empty, 64'd1);
    check_val("rst_aval", addrOut_valid, 64'd0);
    check_val("rst_dval", dataToMem_valid, 64'd0);
    check_val("rst_ardy", addrIn_ready, 64'd0);

    // Test 1: single store, appears next cycle and pops immediately
    rst = 1'b0;
    addrOut_ready   = 1'b1;
    dataToMem_ready = 1'b1;
    drive(32'h10, 32'hAA, 1'b1, 1'b1);
    #1;
    check_val("t1_ardy", addrIn_ready, 64'd1);
    check_val("t1_drdy", dataIn_ready, 64'd1);
    check_val("t1_aval_pre", addrOut_valid, 64'd0);
    tick();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check_val("t1_aval", addrOut_valid, 64'd1);
    check_val("t1_dval", dataToMem_valid, 64'd1);
    check_val("t1_addr", addrOut, 64'h10);
    check_val("t1_data", dataToMem, 64'hAA);
    check_val("t1_pend1", pending_count, 64'd1);
    check_val("t1_empty0", empty, 64'd0);
    tick();
    check_val("t1_pend0", pending_count, 64'd0);
    check_val("t1_empty1", empty, 64'd1);
    check_val("t1_aval_post", addrOut_valid, 64'd0);

    // Test 2: address waits for data
    drive(32'h20, 32'hBB, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("t2_ardy_wait", addrIn_ready, 64'd0);
      check_val("t2_drdy_wait", dataIn_ready, 64'd1);
      check_val("t2_pend_wait", pending_count, 64'd0);
      tick();
    end
    dataIn_valid = 1'b1;
    #1;
    check_val("t2_ardy_join", addrIn_ready, 64'd1);
    tick();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check_val("t2_pend1", pending_count, 64'd1);
    check_val("t2_addr", addrOut, 64'h20);
    check_val("t2_data", dataToMem, 64'hBB);
    tick();
    check_val("t2_pend0", pending_count, 64'd0);

    // Test 3: fill DEPTH=4 with memory stalled, then drain in order
    addrOut_ready   = 1'b0;
    dataToMem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'h100 + 32'(i), 32'h200 + 32'(i), 1'b1, 1'b1);
      #1;
      check_val("t3_fill_ardy", addrIn_ready, 64'd1);
      check_val("t3_fill_pend", pending_count, 64'(i));
      tick();
    end
    drive(32'h104, 32'h204, 1'b1, 1'b1);
    #1;
    check_val("t3_full_pend", pending_count, 64'd4);
    check_val("t3_full_ardy", addrIn_ready, 64'd0);
    check_val("t3_full_drdy", dataIn_ready, 64'd0);
    check_val("t3_head0", addrOut, 64'h100);
    addrOut_ready   = 1'b1;
    dataToMem_ready = 1'b1;
    #1;
    check_val("t3_nopass_ardy", addrIn_ready, 64'd0);
    tick();
    for (int j = 1; j <= 5; j++) begin
      if (j <= 2) begin
        drive(32'h100 + 32'(j + 3), 32'h200 + 32'(j + 3), 1'b1, 1'b1);
      end else begin
        drive(32'h0, 32'h0, 1'b0, 1'b0);
      end
      #1;
      check_val("t3_drain_addr", addrOut, 64'h100 + 64'(j));
      check_val("t3_drain_data", dataToMem, 64'h200 + 64'(j));
      check_val("t3_drain_aval", addrOut_valid, 64'd1);
      check_val("t3_drain_pend", pending_count, (j <= 3) ? 64'd3 : 64'(6 - j));
      if (j <= 2) begin
        check_val("t3_late_ardy", addrIn_ready, 64'd1);
      end
      tick();
    end
    check_val("t3_end_pend", pending_count, 64'd0);
    check_val("t3_end_empty", empty, 64'd1);

    // Test 4: address channel sends once, data channel stalls
    addrOut_ready   = 1'b0;
    dataToMem_ready = 1'b0;
    drive(32'h300, 32'h400, 1'b1, 1'b1);
    tick();
    drive(32'h301, 32'h401, 1'b1, 1'b1);
    tick();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    addrOut_ready = 1'b1;
    #1;
    check_val("t4_aval0", addrOut_valid, 64'd1);
    check_val("t4_dval0", dataToMem_valid, 64'd1);
    check_val("t4_addrA", addrOut, 64'h300);
    tick();
    check_val("t4_aval1", addrOut_valid, 64'd0);
    check_val("t4_dval1", dataToMem_valid, 64'd1);
    check_val("t4_pend", pending_count, 64'd2);
    tick();
    check_val("t4_aval2", addrOut_valid, 64'd0);
    check_val("t4_dval2", dataToMem_valid, 64'd1);
    check_val("t4_dataA", dataToMem, 64'h400);
    dataToMem_ready = 1'b1;
    tick();
    check_val("t4_avalB", addrOut_valid, 64'd1);
    check_val("t4_dvalB", dataToMem_valid, 64'd1);
    check_val("t4_addrB", addrOut, 64'h301);
    check_val("t4_dataB", dataToMem, 64'h401);
    check_val("t4_pendB", pending_count, 64'd1);
    tick();
    check_val("t4_pend0", pending_count, 64'd0);

    // Test 5: full throughput on DEPTH=3 instance across pointer wrap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    addrOut_ready   = 1'b1;
    dataToMem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(32'h500 + 32'(i), 32'h600 + 32'(i), 1'b1, 1'b1);
      #1;
      check_val("t5_ardy", addrIn_ready3, 64'd1);
      check_val("t5_pend", pending_count3, (i == 0) ? 64'd0 : 64'd1);
      if (i > 0) begin
        check_val("t5_addr", addrOut3, 64'h500 + 64'(i - 1));
        check_val("t5_data", dataToMem3, 64'h600 + 64'(i - 1));
        check_val("t5_dval", dataToMem_valid3, 64'd1);
      end
      tick();
    end
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check_val("t5_last_addr", addrOut3, 64'h509);
    check_val("t5_last_data", dataToMem3, 64'h609);
    check_val("t5_last_pend", pending_count3, 64'd1);
    tick();
    check_val("t5_end_pend", pending_count3, 64'd0);
    check_val("t5_end_empty", empty3, 64'd1);

    // Test 6: reset with two entries pending and head half-sent
    addrOut_ready   = 1'b0;
    dataToMem_ready = 1'b0;
    drive(32'h600, 32'h700, 1'b1, 1'b1);
    tick();
    drive(32'h601, 32'h701, 1'b1, 1'b1);
    tick();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    addrOut_ready = 1'b1;
    tick();
    addrOut_ready = 1'b0;
    #1;
    check_val("t6_half_aval", addrOut_valid, 64'd0);
    check_val("t6_half_dval", dataToMem_valid, 64'd1);
    check_val("t6_half_pend", pending_count, 64'd2);
    rst = 1'b1;
    tick();
    check_val("t6_rst_pend", pending_count, 64'd0);
    check_val("t6_rst_aval", addrOut_valid, 64'd0);
    check_val("t6_rst_dval", dataToMem_valid, 64'd0);
    check_val("t6_rst_empty", empty, 64'd1);
    rst = 1'b0;
    addrOut_ready   = 1'b1;
    dataToMem_ready = 1'b1;
    drive(32'h800, 32'h900, 1'b1, 1'b1);
    tick();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check_val("t6_new_aval", addrOut_valid, 64'd1);
    check_val("t6_new_dval", dataToMem_valid, 64'd1);
    check_val("t6_new_addr", addrOut, 64'h800);
    check_val("t6_new_data", dataToMem, 64'h900);
    check_val("t6_new_pend", pending_count, 64'd1);
    tick();
    check_val("t6_end_pend", pending_count, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
